sopc_run_ctrl: RTL and testbench
================================

Name: sopc_run_ctrl

Overview:
- Synthesizable run controller and self-check monitor for the openmips minimal SOPC. It is the parametrised successor to the simulation-only bench harness.
- Sequences the CPU reset, counts execution cycles, and detects program completion via a fetch-address halt marker.
- Folds every register write-back into a signature and reports pass, fail or timeout. Usable on FPGA as well as in simulation.
- Sits beside the openmips core: it drives the core's reset and snoops the instruction fetch and write-back ports.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, write-back data / signature width (>=8)
- CNT_W, 16, cycle and write counter width
- RST_CYCLES, 3, cycles cpu_rst_o is held after start (>=1)
- HALT_ADDR, 32'h0000_0040, fetch address marking program end
- MAX_CYCLES, 20, RUN cycles allowed before timeout (>=2, < 2^CNT_W)
- EXP_SIG, 32'h0000_0021, expected final signature
- TRACE_DEPTH, 8, trace buffer entries (power of 2; optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: begin a run
- inst_ce_i  in  1  core fetch enable
- inst_addr_i  in  ADDR_W  core fetch address
- wb_we_i  in  1  register-file write enable
- wb_addr_i  in  5  register-file write address
- wb_data_i  in  DATA_W  register-file write data
- cpu_rst_o  out  1  core reset, active-high (`RstEnable)
- busy_o  out  1  RESET or RUN state
- done_o  out  1  run finished (halt or timeout), level
- pass_o  out  1  halted and sig_o==EXP_SIG, level
- timeout_o  out  1  MAX_CYCLES exhausted, level
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed
- wb_cnt_o  out  CNT_W  counted write-backs
- sig_o  out  DATA_W  running signature

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; cpu_rst_o=1.
  - busy_o, done_o, pass_o and timeout_o = 0.
  - All counters and sig_o = 0.
- FSM states: IDLE, RESET, RUN, DONE.
  - IDLE: cpu_rst_o=1. start -> RESET; clears counters, sig_o and status.
  - RESET: cpu_rst_o=1 for exactly RST_CYCLES cycles, then -> RUN. cpu_rst_o=0 from the first RUN cycle.
  - RUN: cycle_cnt_o increments every cycle, wrapping at 2^CNT_W (unreachable given the MAX_CYCLES bound).
    - Halt: inst_ce_i=1 and inst_addr_i==HALT_ADDR. Next cycle -> DONE with done_o=1 and pass_o=(sig_o after that cycle's update)==EXP_SIG.
    - Timeout: cycle_cnt_o==MAX_CYCLES-1 with no halt that cycle. Next cycle -> DONE with done_o=1, timeout_o=1, pass_o=0.
    - Halt and timeout in the same cycle: halt wins, timeout_o=0.
  - DONE: cpu_rst_o=1 (core frozen); all outputs held. start -> RESET (counters and status cleared).
- start outside IDLE/DONE is ignored.
- Signature: in RUN only, on wb_we_i=1 with wb_addr_i!=0:
  - sig <= rotl1(sig) ^ wb_data_i ^ zero_extend(wb_addr_i).
  - wb_cnt_o increments.
  - Writes to r0, and writes in any other state, are ignored.
- The write-back on the halt cycle is included in sig_o and in the pass compare.
- rst asserted mid-run: immediate return to IDLE with reset values; no partial status is retained.

Optional Feature:
- Macro: SOPC_RUN_CTRL_TRACE_EN.
- Defined:
  - Adds ports trace_rd_i (in, 1), trace_pc_o (out, ADDR_W) and trace_valid_o (out, 1).
  - In RUN, every inst_ce_i=1 cycle whose address differs from the last recorded address is written into a TRACE_DEPTH circular buffer. Oldest entries are overwritten when full.
  - In DONE, each trace_rd_i pulse pops the oldest entry. It appears on trace_pc_o with trace_valid_o=1 the following cycle; trace_valid_o=0 once the buffer is empty.
  - Buffer cleared on start and on rst.
- Undefined: none of the trace ports or logic exist; all other behaviour is identical.

Test Plan:
- Reset sequencing: rst low 2 cycles, start pulse -> cpu_rst_o stays 1 for exactly 3 cycles after start, then 0; busy_o=1 throughout.
- Signature pass: writes r1=0x10, then r2=0x1, then fetch at 0x40 -> sig_o=0x11 then 0x21; done_o=1, pass_o=1, wb_cnt_o=2.
- Filtering: write r0=0xFFFF_FFFF plus a write during RESET -> sig_o remains 0, wb_cnt_o=0.
- Timeout: no fetch of 0x40 -> done_o=1 and timeout_o=1 after cycle_cnt_o reaches 19; pass_o=0; cpu_rst_o=1.
- Priority: halt fetch on the cycle where cycle_cnt_o=19 -> timeout_o=0, pass_o decided by the signature.
- Abort/restart: rst low mid-RUN -> all outputs return to reset values immediately. A new start repeats the first scenario with identical cycle counts. With the trace macro defined: fetches 0,4,4,8 -> three pops return 0,4,8, the fourth pop gives trace_valid_o=0.

Source files
------------

// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: run controller and self-check monitor for the openmips
// minimal SOPC. It holds the core in reset for RST_CYCLES after a start pulse,
// lets it run, and watches the fetch address for the HALT_ADDR marker. Each
// register write-back is folded into a rotating XOR signature. The block then
// reports pass, fail or timeout.
//
// Optional feature: define SOPC_RUN_CTRL_TRACE_EN to add a fetch-address trace
// buffer (ports trace_rd_i, trace_pc_o, trace_valid_o). When the macro is not
// defined, the trace ports and the trace logic do not exist.
module sopc_run_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 16,
  parameter int                RST_CYCLES  = 3,
  parameter logic [ADDR_W-1:0] HALT_ADDR   = 32'h0000_0040,
  parameter int                MAX_CYCLES  = 20,
  parameter logic [DATA_W-1:0] EXP_SIG     = 32'h0000_0021,
  parameter int                TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
`ifdef SOPC_RUN_CTRL_TRACE_EN
  input  logic              trace_rd_i,
  output logic [ADDR_W-1:0] trace_pc_o,
  output logic              trace_valid_o,
`endif
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  wb_cnt_o,
  output logic [DATA_W-1:0] sig_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RESET = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_CNT_W-1:0] LAST_RST_CYCLE = RST_CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]     LAST_RUN_CYCLE = CNT_W'(MAX_CYCLES - 1);

  logic [1:0]           state_reg,   state_next;
  logic [RST_CNT_W-1:0] rst_cnt_reg, rst_cnt_next;
  logic [CNT_W-1:0]     cycle_reg,   cycle_next;
  logic [CNT_W-1:0]     wb_cnt_reg,  wb_cnt_next;
  logic [DATA_W-1:0]    sig_reg,     sig_next;
  logic                 done_reg,    done_next;
  logic                 pass_reg,    pass_next;
  logic                 timeout_reg, timeout_next;

  logic              in_run;
  logic              start_acc;
  logic              halt_hit;
  logic              wb_hit;
  logic [DATA_W-1:0] sig_upd;
  logic [DATA_W-1:0] sig_after;

  assign in_run    = (state_reg == ST_RUN);
  assign start_acc = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign halt_hit  = in_run && inst_ce_i && (inst_addr_i == HALT_ADDR);
  // Writes to r0 never change the architectural state, so they are not counted.
  assign wb_hit    = in_run && wb_we_i && (wb_addr_i != 5'd0);
  assign sig_upd   = {sig_reg[DATA_W-2:0], sig_reg[DATA_W-1]} ^ wb_data_i
                     ^ DATA_W'(wb_addr_i);
  // The pass decision sees the signature including a write-back on the halt cycle.
  assign sig_after = wb_hit ? sig_upd : sig_reg;

  // Next-state logic for the run sequencer, counters, signature and status.
  always_comb begin
    state_next   = state_reg;
    rst_cnt_next = rst_cnt_reg;
    cycle_next   = cycle_reg;
    wb_cnt_next  = wb_cnt_reg;
    sig_next     = sig_reg;
    done_next    = done_reg;
    pass_next    = pass_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          state_next   = ST_RESET;
          rst_cnt_next = '0;
          cycle_next   = '0;
          wb_cnt_next  = '0;
          sig_next     = '0;
          done_next    = 1'b0;
          pass_next    = 1'b0;
          timeout_next = 1'b0;
        end
      end
      ST_RESET: begin
        if (rst_cnt_reg == LAST_RST_CYCLE) begin
          state_next = ST_RUN;
        end else begin
          rst_cnt_next = rst_cnt_reg + RST_CNT_W'(1);
        end
      end
      ST_RUN: begin
        cycle_next = cycle_reg + CNT_W'(1);
        sig_next   = sig_after;
        if (wb_hit) begin
          wb_cnt_next = wb_cnt_reg + CNT_W'(1);
        end
        // A halt wins over a timeout that falls on the same cycle.
        if (halt_hit) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
          pass_next  = (sig_after == EXP_SIG);
        end else if (cycle_reg == LAST_RUN_CYCLE) begin
          state_next   = ST_DONE;
          done_next    = 1'b1;
          timeout_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register the sequencer state. Reset is asynchronous and clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      rst_cnt_reg <= '0;
      cycle_reg   <= '0;
      wb_cnt_reg  <= '0;
      sig_reg     <= '0;
      done_reg    <= 1'b0;
      pass_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rst_cnt_reg <= rst_cnt_next;
      cycle_reg   <= cycle_next;
      wb_cnt_reg  <= wb_cnt_next;
      sig_reg     <= sig_next;
      done_reg    <= done_next;
      pass_reg    <= pass_next;
      timeout_reg <= timeout_next;
    end
  end

  // The core is released only while running. It is frozen in IDLE, RESET and DONE.
  assign cpu_rst_o   = ~in_run;
  assign busy_o      = (state_reg == ST_RESET) || in_run;
  assign done_o      = done_reg;
  assign pass_o      = pass_reg;
  assign timeout_o   = timeout_reg;
  assign cycle_cnt_o = cycle_reg;
  assign wb_cnt_o    = wb_cnt_reg;
  assign sig_o       = sig_reg;

`ifdef SOPC_RUN_CTRL_TRACE_EN
  localparam int TR_PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic [TR_PTR_W:0] TR_FULL = (TR_PTR_W + 1)'(TRACE_DEPTH);

  logic [ADDR_W-1:0]   tr_mem [TRACE_DEPTH];
  logic [TR_PTR_W-1:0] tr_wr_ptr_reg, tr_wr_ptr_next;
  logic [TR_PTR_W-1:0] tr_rd_ptr_reg, tr_rd_ptr_next;
  logic [TR_PTR_W:0]   tr_cnt_reg,    tr_cnt_next;
  logic [ADDR_W-1:0]   tr_last_reg,   tr_last_next;
  logic                tr_last_vld_reg, tr_last_vld_next;
  logic                tr_valid_reg;
  logic [ADDR_W-1:0]   tr_pc_reg;
  logic                tr_rec;
  logic                tr_pop;
  logic                tr_full;

  // Consecutive fetches of the same address (stalls) are recorded only once.
  assign tr_rec  = in_run && inst_ce_i
                   && (!tr_last_vld_reg || (inst_addr_i != tr_last_reg));
  assign tr_full = (tr_cnt_reg == TR_FULL);
  assign tr_pop  = (state_reg == ST_DONE) && trace_rd_i && (tr_cnt_reg != '0)
                   && !start_acc;

  // Trace pointer bookkeeping. When the buffer is full, a new entry drops the oldest one.
  always_comb begin
    tr_wr_ptr_next   = tr_wr_ptr_reg;
    tr_rd_ptr_next   = tr_rd_ptr_reg;
    tr_cnt_next      = tr_cnt_reg;
    tr_last_next     = tr_last_reg;
    tr_last_vld_next = tr_last_vld_reg;
    if (start_acc) begin
      tr_wr_ptr_next   = '0;
      tr_rd_ptr_next   = '0;
      tr_cnt_next      = '0;
      tr_last_vld_next = 1'b0;
    end else if (tr_rec) begin
      tr_wr_ptr_next   = tr_wr_ptr_reg + TR_PTR_W'(1);
      tr_last_next     = inst_addr_i;
      tr_last_vld_next = 1'b1;
      if (tr_full) begin
        tr_rd_ptr_next = tr_rd_ptr_reg + TR_PTR_W'(1);
      end else begin
        tr_cnt_next = tr_cnt_reg + (TR_PTR_W + 1)'(1);
      end
    end else if (tr_pop) begin
      tr_rd_ptr_next = tr_rd_ptr_reg + TR_PTR_W'(1);
      tr_cnt_next    = tr_cnt_reg - (TR_PTR_W + 1)'(1);
    end
  end

  // Trace control registers. Reset is asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tr_wr_ptr_reg   <= '0;
      tr_rd_ptr_reg   <= '0;
      tr_cnt_reg      <= '0;
      tr_last_reg     <= '0;
      tr_last_vld_reg <= 1'b0;
      tr_valid_reg    <= 1'b0;
    end else begin
      tr_wr_ptr_reg   <= tr_wr_ptr_next;
      tr_rd_ptr_reg   <= tr_rd_ptr_next;
      tr_cnt_reg      <= tr_cnt_next;
      tr_last_reg     <= tr_last_next;
      tr_last_vld_reg <= tr_last_vld_next;
      tr_valid_reg    <= tr_pop;
    end
  end

  // Trace storage: a write port and a registered read port, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (tr_rec && !start_acc) begin
      tr_mem[tr_wr_ptr_reg] <= inst_addr_i;
    end
    if (tr_pop) begin
      tr_pc_reg <= tr_mem[tr_rd_ptr_reg];
    end
  end

  assign trace_pc_o    = tr_pc_reg;
  assign trace_valid_o = tr_valid_reg;
`endif

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Testbench for sopc_run_ctrl. Per-run stimulus tables are either randomized
// or directed. A reference model computes the expected final status of each
// run from the behavioural rules, and that result is queued. A monitor pops
// and compares the queued result when done_o rises.
`timescale 1ns/1ps
module tb_sopc_run_ctrl;
  localparam int          MAXC = 20;
  localparam logic [31:0] HALT = 32'h0000_0040;
  localparam logic [31:0] EXPS = 32'h0000_0021;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        inst_ce = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        cpu_rst_o, busy_o, done_o, pass_o, timeout_o;
  logic [15:0] cycle_cnt_o, wb_cnt_o;
  logic [31:0] sig_o;
`ifdef SOPC_RUN_CTRL_TRACE_EN
  logic        trace_rd = 1'b0;
  logic [31:0] trace_pc_o;
  logic        trace_valid_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [15:0] cyc;
    logic [15:0] wbc;
    logic [31:0] sig;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;

  // Per-RUN-cycle stimulus table for the current run.
  logic        cs_ce [MAXC];
  logic [31:0] cs_addr [MAXC];
  logic        cs_we [MAXC];
  logic [4:0]  cs_wa [MAXC];
  logic [31:0] cs_wd [MAXC];

  sopc_run_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .inst_ce_i   (inst_ce),
    .inst_addr_i (inst_addr),
    .wb_we_i     (wb_we),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
`ifdef SOPC_RUN_CTRL_TRACE_EN
    .trace_rd_i    (trace_rd),
    .trace_pc_o    (trace_pc_o),
    .trace_valid_o (trace_valid_o),
`endif
    .cpu_rst_o   (cpu_rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .timeout_o   (timeout_o),
    .cycle_cnt_o (cycle_cnt_o),
    .wb_cnt_o    (wb_cnt_o),
    .sig_o       (sig_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fold(input logic [31:0] s, input logic [4:0] a,
                                       input logic [31:0] d);
    return {s[30:0], s[31]} ^ d ^ {27'd0, a};
  endfunction

  // Reference model: walk the RUN cycles of the table and apply the run rules.
  function automatic exp_t model();
    exp_t        e;
    logic [31:0] s;
    int          n;
    s = '0;
    n = 0;
    e.pass = 1'b0; e.timeout = 1'b0; e.cyc = '0; e.wbc = '0; e.sig = '0;
    for (int i = 0; i < MAXC; i++) begin
      if (cs_we[i] && cs_wa[i] != 5'd0) begin
        s = fold(s, cs_wa[i], cs_wd[i]);
        n++;
      end
      if (cs_ce[i] && cs_addr[i] == HALT) begin
        e.pass = (s == EXPS);
        e.cyc  = 16'(i + 1);
        e.wbc  = 16'(n);
        e.sig  = s;
        return e;
      end
    end
    e.timeout = 1'b1;
    e.cyc     = 16'(MAXC);
    e.wbc     = 16'(n);
    e.sig     = s;
    return e;
  endfunction

  // Monitor: on each rising done_o, compare the final status against the oldest expectation.
  always @(negedge clk) begin
    if (done_o && !done_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done actual=done required=no_run_pending");
      end else begin
        mon_e = sb_q.pop_front();
        chk("end_pass", 32'(pass_o), 32'(mon_e.pass));
        chk("end_timeout", 32'(timeout_o), 32'(mon_e.timeout));
        chk("end_cycle_cnt", 32'(cycle_cnt_o), 32'(mon_e.cyc));
        chk("end_wb_cnt", 32'(wb_cnt_o), 32'(mon_e.wbc));
        chk("end_sig", sig_o, mon_e.sig);
        $display("run end: pass=%0d timeout=%0d cycles=%0d wbs=%0d sig=%h",
                 pass_o, timeout_o, cycle_cnt_o, wb_cnt_o, sig_o);
      end
    end
    done_prev <= done_o;
  end

  task automatic gen_idle();
    for (int i = 0; i < MAXC; i++) begin
      cs_ce[i] = 1'b1; cs_addr[i] = 32'h100 + 32'(4 * i);
      cs_we[i] = 1'b0; cs_wa[i] = '0; cs_wd[i] = '0;
    end
  endtask

  task automatic gen_pass();
    gen_idle();
    cs_we[1] = 1'b1; cs_wa[1] = 5'd1; cs_wd[1] = 32'h10;
    cs_we[3] = 1'b1; cs_wa[3] = 5'd2; cs_wd[3] = 32'h1;
    cs_addr[5] = HALT;
  endtask

  task automatic gen_rand();
    for (int i = 0; i < MAXC; i++) begin
      cs_ce[i]   = 1'($urandom_range(0, 1));
      cs_addr[i] = ($urandom_range(0, 11) == 0) ? HALT : ($urandom | 32'h1000);
      cs_we[i]   = 1'($urandom_range(0, 1));
      cs_wa[i]   = 5'($urandom_range(0, 31));
      cs_wd[i]   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
    end
  endtask

  task automatic idle_inputs();
    inst_ce = 1'b0; inst_addr = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; start = 1'b0;
  endtask

  // One complete run: start, RESET sequencing, RUN from the table, then a DONE hold check.
  task automatic do_run(input bit abort, input int abort_at, input bit rand_start);
    exp_t        e;
    logic [31:0] s;
    int          n;
    int          w;
    bit          halted;
    e = model();
    if (!abort) sb_q.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_clears_done", 32'(done_o), 32'd0);
    chk("start_clears_sig", sig_o, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("rst_seq_cpu_rst", 32'(cpu_rst_o), 32'd1);
      chk("rst_seq_busy", 32'(busy_o), 32'd1);
      // Write-backs and halt fetches during RESET must be ignored.
      wb_we = 1'b1; wb_addr = 5'($urandom_range(1, 31)); wb_data = $urandom;
      inst_ce = 1'b1; inst_addr = HALT;
      @(negedge clk);
    end
    chk("run_cpu_rst", 32'(cpu_rst_o), 32'd0);
    s = '0; n = 0; halted = 1'b0;
    for (int i = 0; i < MAXC && !halted; i++) begin
      chk("run_cycle_cnt", 32'(cycle_cnt_o), 32'(i));
      chk("run_sig", sig_o, s);
      chk("run_wb_cnt", 32'(wb_cnt_o), 32'(n));
      inst_ce = cs_ce[i]; inst_addr = cs_addr[i];
      wb_we = cs_we[i]; wb_addr = cs_wa[i]; wb_data = cs_wd[i];
      start = rand_start ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (abort && i == abort_at) begin
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("abort_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_pass", 32'(pass_o), 32'd0);
        chk("abort_timeout", 32'(timeout_o), 32'd0);
        chk("abort_cycle_cnt", 32'(cycle_cnt_o), 32'd0);
        chk("abort_wb_cnt", 32'(wb_cnt_o), 32'd0);
        chk("abort_sig", sig_o, 32'd0);
        $display("abort at run cycle %0d", i);
        @(negedge clk); rst = 1'b1;
        return;
      end
      if (cs_we[i] && cs_wa[i] != 5'd0) begin
        s = fold(s, cs_wa[i], cs_wd[i]);
        n++;
      end
      if (cs_ce[i] && cs_addr[i] == HALT) halted = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    idle_inputs();
    w = 0;
    while (!done_o && w < 4) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", 32'(done_o), 32'd1);
    chk("done_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("done_busy", 32'(busy_o), 32'd0);
    // In DONE, activity on the core ports must not disturb the held results.
    for (int k = 0; k < 2; k++) begin
      wb_we = 1'b1; wb_addr = 5'($urandom_range(1, 31)); wb_data = $urandom;
      inst_ce = 1'b1; inst_addr = HALT;
      @(negedge clk);
      chk("hold_sig", sig_o, e.sig);
      chk("hold_cycle_cnt", 32'(cycle_cnt_o), 32'(e.cyc));
      chk("hold_done", 32'(done_o), 32'd1);
      chk("hold_timeout", 32'(timeout_o), 32'(e.timeout));
    end
    idle_inputs();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_pass", 32'(pass_o), 32'd0);
    chk("reset_timeout", 32'(timeout_o), 32'd0);
    chk("reset_cycle_cnt", 32'(cycle_cnt_o), 32'd0);
    chk("reset_wb_cnt", 32'(wb_cnt_o), 32'd0);
    chk("reset_sig", sig_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_cpu_rst", 32'(cpu_rst_o), 32'd1);

    // Signature pass scenario.
    gen_pass(); do_run(1'b0, 0, 1'b0);

    // Filtering: an r0 write in RUN (RESET-phase writes are driven in every run).
    gen_idle(); cs_we[2] = 1'b1; cs_wa[2] = 5'd0; cs_wd[2] = 32'hFFFF_FFFF; cs_addr[4] = HALT;
    do_run(1'b0, 0, 1'b0);

    // Timeout with no halt fetch.
    gen_idle(); cs_we[0] = 1'b1; cs_wa[0] = 5'd3; cs_wd[0] = 32'h55;
    do_run(1'b0, 0, 1'b0);

    // Halt on the last allowed cycle, including a write on that cycle: matching signature.
    gen_idle(); cs_we[0] = 1'b1; cs_wa[0] = 5'd1; cs_wd[0] = 32'h10;
    cs_we[MAXC-1] = 1'b1; cs_wa[MAXC-1] = 5'd2; cs_wd[MAXC-1] = 32'h1; cs_addr[MAXC-1] = HALT;
    do_run(1'b0, 0, 1'b0);

    // Halt on the last allowed cycle with a non-matching signature.
    gen_idle(); cs_we[7] = 1'b1; cs_wa[7] = 5'd9; cs_wd[7] = 32'hABCD; cs_addr[MAXC-1] = HALT;
    do_run(1'b0, 0, 1'b0);

    // Abort mid-run, then repeat the pass scenario from scratch.
    gen_pass(); do_run(1'b1, 3, 1'b0);
    gen_pass(); do_run(1'b0, 0, 1'b0);

`ifdef SOPC_RUN_CTRL_TRACE_EN
    // Trace: fetches 0,4,4,8 only, then timeout and drain the buffer.
    gen_idle();
    for (int i = 0; i < MAXC; i++) cs_ce[i] = 1'b0;
    cs_ce[0] = 1'b1; cs_addr[0] = 32'h0;
    cs_ce[1] = 1'b1; cs_addr[1] = 32'h4;
    cs_ce[2] = 1'b1; cs_addr[2] = 32'h4;
    cs_ce[3] = 1'b1; cs_addr[3] = 32'h8;
    do_run(1'b0, 0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(4 * p);
      trace_rd = 1'b1;
      @(negedge clk);
      trace_rd = 1'b0;
      chk("trace_valid", 32'(trace_valid_o), (p < 3) ? 32'd1 : 32'd0);
      if (p < 3) chk("trace_pc", trace_pc_o, exp_pc);
      $display("trace pop %0d: valid=%0d pc=%h", p, trace_valid_o, trace_pc_o);
    end
`endif

    // Randomized runs; stray start pulses during RUN must be ignored.
    repeat (15) begin
      gen_rand();
      do_run(1'b0, 0, 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
